seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter: drives a bit stream that carries a fixed bit pattern
//  (default 1101), repeated a programmable number of times, with optional zero gaps.
//  Produces the Din stimulus that the 1101 sequence detectors consume, for on-chip
//  self-test and for loopback checks.
//  Bits go out MSB-first, one per accepted cycle, under a valid/ready handshake.
// PARAMETERS
//  PAT_W    4        pattern width in bits (>=2)
//  PAT      4'b1101  pattern; bit PAT_W-1 is sent first
//  CNT_W    8        width of the repetition count Rep
//  GAP_LEN  0        number of '0' bits inserted between repetitions (0 = back-to-back)
// PORTS
//  Clk     in   1      clock, rising edge
//  Rst     in   1      asynchronous reset, active-high
//  Start   in   1      begin a burst; sampled only in IDLE
//  Rep     in   CNT_W  repetitions for this burst; latched when Start is accepted
//  Abort   in   1      synchronous abort of the current burst
//  Ready   in   1      consumer accepts Dout this cycle
//  Dout    out  1      serial data bit
//  Dvalid  out  1      Dout is valid
//  Busy    out  1      burst in progress (SHIFT or GAP)
//  Done    out  1      one-cycle pulse after the last bit of a burst is accepted
// BEHAVIOUR
//  - Rst high, at any time, including mid-burst: go to IDLE at once. Outputs Dout,
//    Dvalid, Busy and Done = 0. Bit index, repetition and gap counters clear to 0.
//  - States: IDLE, SHIFT, GAP, DONE. Dout, Dvalid and Busy decode from registered state:
//    SHIFT: Dvalid=1, Dout=PAT[idx]; GAP: Dvalid=1, Dout=0; IDLE/DONE: Dvalid=0, Dout=0.
//    Busy=1 in SHIFT and GAP only. Done=1 in DONE only.
//  - Transfer: a transfer occurs on a rising edge when Dvalid=1 and Ready=1.
//    With Ready=0, state, idx, Dout and the counters hold.
//  - IDLE: Start=1 and Rep!=0 -> SHIFT, idx=PAT_W-1, rep_cnt=Rep.
//    The first bit is valid the cycle after Start (latency 1).
//    Start with Rep=0 is ignored: stay in IDLE, no Done.
//  - SHIFT, transfer with idx>0: idx decrements.
//    SHIFT, transfer with idx==0: rep_cnt decrements, then:
//      rep_cnt was 1               -> DONE
//      else if GAP_LEN>0           -> GAP, gap_cnt=GAP_LEN-1
//      else                        -> SHIFT, idx=PAT_W-1
//  - GAP, transfer: gap_cnt==0 -> SHIFT, idx=PAT_W-1; else gap_cnt decrements.
//    No gap is sent after the last repetition.
//  - DONE: lasts one cycle, then IDLE. A Start in IDLE on the next cycle is accepted.
//  - Start while not in IDLE is ignored. Rep is not re-sampled during a burst.
//  - Abort=1 in SHIFT, GAP or DONE: next state IDLE, no Done pulse.
//    Abort has priority over a simultaneous transfer.
//    Abort with Start in IDLE: Abort wins, the burst does not start.
//  - Widths: idx is $clog2(PAT_W), rep_cnt is CNT_W, gap_cnt is max($clog2(GAP_LEN),1).
//    Counters never wrap; a burst totals Rep*PAT_W + (Rep-1)*GAP_LEN accepted bits.
// TESTING
//  1. Defaults, Ready=1, Start with Rep=1 -> Dout 1,1,0,1 on cycles 1-4, Done=1 on
//     cycle 5; detector Y=1 on the 4th bit.
//  2. Rep=3, GAP_LEN=0, Ready=1 -> 12 bits 110111011101, Busy=1 for 12 cycles, Done
//     once; detector fires 3 times (overlapping patterns).
//  3. Rep=2, GAP_LEN=2 -> 1101 00 1101, 10 transfers, no trailing gap, Done after
//     the 10th transfer.
//  4. Rep=1, Ready toggling 1,0,0,1,... -> Dout/idx hold while Ready=0; exactly 4
//     transfers, bit order 1101.
//  5. Abort after the 2nd bit of Rep=2 -> IDLE next cycle, Dvalid=0, no Done; a new
//     Start with Rep=1 then sends a clean 1101.
//  6. Rst asserted mid-SHIFT -> all outputs 0 with no clock edge; Start with Rep=0 ->
//     stays IDLE, no Done.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Handshake bundle of the serial pattern transmitter: burst control in, serial stream out.
// The master side is the transmitter; the slave side is the controller/consumer.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 8
);
    logic             Start;
    logic [CNT_W-1:0] Rep;
    logic             Abort;
    logic             Ready;
    logic             Dout;
    logic             Dvalid;
    logic             Busy;
    logic             Done;

    modport master (
        input  Start, Rep, Abort, Ready,
        output Dout, Dvalid, Busy, Done
    );

    modport slave (
        output Start, Rep, Abort, Ready,
        input  Dout, Dvalid, Busy, Done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PAT MSB-first Rep times with optional zero gaps
// under a valid/ready handshake; outputs decode directly from the registered state.
module seq_pattern_tx #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT   = 4'b1101,
    parameter int             CNT_W   = 8,
    parameter int             GAP_LEN = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    seq_pattern_tx_if.master  bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] rep_q,   rep_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             xfer;

    assign bus.Dvalid = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign bus.Busy   = bus.Dvalid;
    assign bus.Done   = (state_q == S_DONE);
    assign bus.Dout   = (state_q == S_SHIFT) ? PAT[idx_q] : 1'b0;
    assign xfer       = bus.Dvalid && bus.Ready;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
        end
    end

    // NOTE: every signal gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                // Abort outranks Start; a zero repetition count never opens a burst.
                if (!bus.Abort && bus.Start && (bus.Rep != '0)) begin
                    state_d = S_SHIFT;
                    idx_d   = IDX_LAST;
                    rep_d   = bus.Rep;
                end
            end
            S_SHIFT: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        if (rep_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (GAP_LEN > 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_INIT;
                        end else begin
                            idx_d = IDX_LAST;
                        end
                    end
                end
            end
            S_GAP: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (gap_q == '0) begin
                        state_d = S_SHIFT;
                        idx_d   = IDX_LAST;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
